// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: decodes Opcode/Func/ALUOp into an ALU control word and
// sequences each op over its execute cycles (vector passes, multiply latency).
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   Start               decode presents a new op (taken only when !Stall)
//   Opcode, Func, ALUOp instruction fields; ALUOp=0 forces add
//   OpValid             ALUControl/PassIdx valid for execute this cycle
//   ALUControl, ALUSel  ALU operation, 1 = vector datapath
//   PassIdx             current lane group
//   Last                final execute cycle of the op
//   Stall               hold upstream pipeline
//   FlagWrite           flag write enables (scalar ops, Last cycle only)
//   IllegalOp           one-cycle pulse on an undecodable op
module alu_op_sequencer #(
   parameter int unsigned VLEN    = 16,
   parameter int unsigned LANES   = 4,
   parameter int unsigned MUL_LAT = 2,
   localparam int unsigned NPASS  = VLEN / LANES,
   localparam int unsigned PW     = (NPASS > 1) ? $clog2(NPASS) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          Start,
   input  logic [5:0]    Opcode,
   input  logic [2:0]    Func,
   input  logic          ALUOp,
   output logic          OpValid,
   output logic [2:0]    ALUControl,
   output logic          ALUSel,
   output logic [PW-1:0] PassIdx,
   output logic          Last,
   output logic          Stall,
   output logic [1:0]    FlagWrite,
   output logic          IllegalOp
);

   localparam int unsigned CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
   localparam logic [2:0]  CTL_MUL = 3'b010;

   typedef enum logic {IDLE, EXEC} state_e;

   state_e          state_q, state_d;
   logic            op_valid_q, op_valid_d;
   logic [2:0]      alu_ctl_q, alu_ctl_d;
   logic            alu_sel_q, alu_sel_d;
   logic [PW-1:0]   pass_q, pass_d;
   logic [CW-1:0]   cyc_q, cyc_d;
   logic            is_mul_q, is_mul_d;
   logic            last_q, last_d;
   logic            stall_q, stall_d;
   logic [1:0]      flag_q, flag_d;
   logic            illegal_q, illegal_d;

   logic [2:0]      dec_ctl;
   logic            dec_vec;
   logic            dec_ill;
   logic            accept;

   // Instruction decode of the presented op
   always_comb begin
      dec_ctl = 3'b000;
      dec_vec = 1'b0;
      dec_ill = 1'b0;
      if (ALUOp) begin
         case (Opcode)
            6'b000000: begin
               if (Func == 3'b100 || Func == 3'b110) dec_ill = 1'b1;
               else                                  dec_ctl = Func;
            end
            6'b100000: begin
               case (Func)
                  3'b000, 3'b001, 3'b010, 3'b101: begin
                     dec_ctl = Func;
                     dec_vec = 1'b1;
                  end
                  default: dec_ill = 1'b1;
               endcase
            end
            6'b001000: dec_ctl = 3'b000;
            6'b001001: dec_ctl = 3'b001;
            6'b001010: dec_ctl = 3'b010;
            6'b000100: dec_ctl = 3'b001;
            default:   dec_ctl = 3'b000;
         endcase
      end
   end

   // Start is only taken when not stalled, i.e. in IDLE or on a Last cycle
   assign accept = Start && !stall_q;

   // Next state and next registered outputs
   always_comb begin
      state_d    = IDLE;
      op_valid_d = 1'b0;
      alu_ctl_d  = 3'b000;
      alu_sel_d  = 1'b0;
      pass_d     = '0;
      cyc_d      = '0;
      is_mul_d   = 1'b0;
      illegal_d  = 1'b0;
      if (accept) begin
         if (dec_ill) begin
            illegal_d = 1'b1;
         end else begin
            state_d    = EXEC;
            op_valid_d = 1'b1;
            alu_ctl_d  = dec_ctl;
            alu_sel_d  = dec_vec;
            is_mul_d   = (dec_ctl == CTL_MUL);
         end
      end else if (state_q == EXEC && !last_q) begin
         state_d    = EXEC;
         op_valid_d = 1'b1;
         alu_ctl_d  = alu_ctl_q;
         alu_sel_d  = alu_sel_q;
         is_mul_d   = is_mul_q;
         // Multiply passes dwell MUL_LAT cycles before the lane group advances
         if (is_mul_q && cyc_q != CW'(MUL_LAT - 1)) begin
            cyc_d  = cyc_q + 1'b1;
            pass_d = pass_q;
         end else begin
            pass_d = pass_q + 1'b1;
         end
      end
      last_d  = op_valid_d
              && (pass_d == (alu_sel_d ? PW'(NPASS - 1) : PW'(0)))
              && (!is_mul_d || cyc_d == CW'(MUL_LAT - 1));
      stall_d = op_valid_d && !last_d;
      flag_d  = (op_valid_d && last_d && !alu_sel_d) ? 2'b11 : 2'b00;
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         op_valid_q <= 1'b0;
         alu_ctl_q  <= 3'b000;
         alu_sel_q  <= 1'b0;
         pass_q     <= '0;
         cyc_q      <= '0;
         is_mul_q   <= 1'b0;
         last_q     <= 1'b0;
         stall_q    <= 1'b0;
         flag_q     <= 2'b00;
         illegal_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_valid_q <= op_valid_d;
         alu_ctl_q  <= alu_ctl_d;
         alu_sel_q  <= alu_sel_d;
         pass_q     <= pass_d;
         cyc_q      <= cyc_d;
         is_mul_q   <= is_mul_d;
         last_q     <= last_d;
         stall_q    <= stall_d;
         flag_q     <= flag_d;
         illegal_q  <= illegal_d;
      end
   end

   assign OpValid    = op_valid_q;
   assign ALUControl = alu_ctl_q;
   assign ALUSel     = alu_sel_q;
   assign PassIdx    = pass_q;
   assign Last       = last_q;
   assign Stall      = stall_q;
   assign FlagWrite  = flag_q;
   assign IllegalOp  = illegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: directed vector table followed by random
// op streams checked against a per-op expansion model.
module tb_alu_op_sequencer;

   localparam int unsigned VLEN    = 16;
   localparam int unsigned LANES   = 4;
   localparam int unsigned MUL_LAT = 2;
   localparam int unsigned NPASS   = VLEN / LANES;

   typedef struct packed {
      logic       opv;
      logic [2:0] ctl;
      logic       sel;
      logic [1:0] pidx;
      logic       last;
      logic       stall;
      logic [1:0] fw;
      logic       ill;
   } out_t;

   typedef struct {
      logic       rst;
      logic       st;
      logic [5:0] opc;
      logic [2:0] fn;
      logic       aop;
      out_t       exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       Start = 1'b0;
   logic [5:0] Opcode = '0;
   logic [2:0] Func = '0;
   logic       ALUOp = 1'b0;
   logic       OpValid;
   logic [2:0] ALUControl;
   logic       ALUSel;
   logic [1:0] PassIdx;
   logic       Last;
   logic       Stall;
   logic [1:0] FlagWrite;
   logic       IllegalOp;

   int   n_cmp = 0;
   int   n_err = 0;
   vec_t tbl[$];
   out_t q[$];
   out_t cur;

   alu_op_sequencer #(.VLEN(VLEN), .LANES(LANES), .MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .reset(reset), .Start(Start), .Opcode(Opcode), .Func(Func),
      .ALUOp(ALUOp), .OpValid(OpValid), .ALUControl(ALUControl), .ALUSel(ALUSel),
      .PassIdx(PassIdx), .Last(Last), .Stall(Stall), .FlagWrite(FlagWrite),
      .IllegalOp(IllegalOp)
   );

   always #5 clk = ~clk;

   function automatic out_t mk(int opv, int ctl, int sel, int p, int last,
                               int stall, int fw, int ill);
      out_t r;
      r.opv = 1'(opv);  r.ctl = 3'(ctl);    r.sel = 1'(sel); r.pidx = 2'(p);
      r.last = 1'(last); r.stall = 1'(stall); r.fw = 2'(fw);  r.ill = 1'(ill);
      return r;
   endfunction

   task automatic add(int rst, int st, int opc, int fn, int aop, out_t e);
      vec_t v;
      v.rst = 1'(rst); v.st = 1'(st); v.opc = 6'(opc); v.fn = 3'(fn);
      v.aop = 1'(aop); v.exp = e;
      tbl.push_back(v);
   endtask

   task automatic check(string name, out_t exp);
      out_t act;
      act = {OpValid, ALUControl, ALUSel, PassIdx, Last, Stall, FlagWrite, IllegalOp};
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got opv=%b ctl=%b sel=%b pidx=%0d last=%b stall=%b fw=%b ill=%b, want opv=%b ctl=%b sel=%b pidx=%0d last=%b stall=%b fw=%b ill=%b",
                  name, act.opv, act.ctl, act.sel, act.pidx, act.last, act.stall, act.fw, act.ill,
                  exp.opv, exp.ctl, exp.sel, exp.pidx, exp.last, exp.stall, exp.fw, exp.ill);
      end
   endtask

   // Reference: expand an accepted op into its full list of per-cycle outputs
   task automatic expand(logic [5:0] opc, logic [2:0] fn, logic aop);
      int ctl = 0;
      int vec = 0;
      int ill = 0;
      int npass, per, total;
      if (aop) begin
         case (opc)
            6'b000000: if (fn inside {3'b100, 3'b110}) ill = 1; else ctl = int'(fn);
            6'b100000: if (fn inside {3'b000, 3'b001, 3'b010, 3'b101}) begin
                          ctl = int'(fn); vec = 1;
                       end else ill = 1;
            6'b001000: ctl = 0;
            6'b001001: ctl = 1;
            6'b001010: ctl = 2;
            6'b000100: ctl = 1;
            default:   ctl = 0;
         endcase
      end
      if (ill != 0) begin
         q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
      end else begin
         npass = (vec != 0) ? int'(NPASS) : 1;
         per   = (ctl == 2) ? int'(MUL_LAT) : 1;
         total = npass * per;
         for (int k = 0; k < total; k++) begin
            int lst;
            lst = (k == total - 1) ? 1 : 0;
            q.push_back(mk(1, ctl, vec, k / per, lst, 1 - lst,
                           (lst != 0 && vec == 0) ? 3 : 0, 0));
         end
      end
   endtask

   initial begin
      out_t z;
      z = '0;

      // Directed vectors: expected outputs are for the cycle after the inputs
      add(1, 0, 0, 0, 0, z);
      add(1, 0, 0, 0, 0, z);
      add(0, 0, 0, 0, 0, z);
      add(0, 1, 6'b000000, 3'b000, 1, mk(1, 0, 0, 0, 1, 0, 3, 0));
      add(0, 0, 0, 0, 0, z);
      add(0, 1, 6'b100000, 3'b010, 1, mk(1, 2, 1, 0, 0, 1, 0, 0));
      for (int k = 1; k < 8; k++)
         add(0, 0, 0, 0, 0, mk(1, 2, 1, k / 2, (k == 7) ? 1 : 0, (k == 7) ? 0 : 1, 0, 0));
      add(0, 1, 6'b000000, 3'b100, 1, mk(0, 0, 0, 0, 0, 0, 0, 1));
      add(0, 0, 0, 0, 0, z);
      add(0, 1, 6'b001001, 3'b000, 1, mk(1, 1, 0, 0, 1, 0, 3, 0));
      add(0, 1, 6'b100000, 3'b001, 1, mk(1, 1, 1, 0, 0, 1, 0, 0));
      add(0, 1, 6'b000000, 3'b000, 1, mk(1, 1, 1, 1, 0, 1, 0, 0));
      add(0, 0, 0, 0, 0, mk(1, 1, 1, 2, 0, 1, 0, 0));
      add(0, 0, 0, 0, 0, mk(1, 1, 1, 3, 1, 0, 0, 0));
      add(0, 1, 6'b000100, 3'b000, 1, mk(1, 1, 0, 0, 1, 0, 3, 0));
      add(0, 0, 0, 0, 0, z);
      add(0, 1, 6'b100000, 3'b010, 0, mk(1, 0, 0, 0, 1, 0, 3, 0));
      add(0, 1, 6'b100000, 3'b010, 1, mk(1, 2, 1, 0, 0, 1, 0, 0));
      add(0, 0, 0, 0, 0, mk(1, 2, 1, 0, 0, 1, 0, 0));
      add(0, 0, 0, 0, 0, mk(1, 2, 1, 1, 0, 1, 0, 0));
      add(1, 1, 6'b100000, 3'b010, 1, z);
      add(0, 0, 0, 0, 0, z);
      add(0, 1, 6'b000000, 3'b010, 1, mk(1, 2, 0, 0, 0, 1, 0, 0));
      add(0, 0, 0, 0, 0, mk(1, 2, 0, 0, 1, 0, 3, 0));
      add(0, 1, 6'b100000, 3'b111, 1, mk(0, 0, 0, 0, 0, 0, 0, 1));
      add(0, 0, 0, 0, 0, z);
      add(0, 1, 6'b111111, 3'b000, 1, mk(1, 0, 0, 0, 1, 0, 3, 0));
      add(0, 0, 0, 0, 0, z);

      foreach (tbl[i]) begin
         reset  = tbl[i].rst;
         Start  = tbl[i].st;
         Opcode = tbl[i].opc;
         Func   = tbl[i].fn;
         ALUOp  = tbl[i].aop;
         @(posedge clk);
         @(negedge clk);
         check($sformatf("vec%0d", i), tbl[i].exp);
      end

      // Random op streams against the expansion model
      reset = 1'b1; Start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      cur = '0;
      q.delete();
      for (int n = 0; n < 2000; n++) begin
         logic       r_rst, r_st, r_aop;
         logic [5:0] r_opc;
         logic [2:0] r_fn;
         check($sformatf("rnd%0d", n), cur);
         r_rst = ($urandom_range(0, 99) == 0);
         r_st  = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 7))
            0, 1:    r_opc = 6'b000000;
            2, 3:    r_opc = 6'b100000;
            4:       r_opc = 6'b001000;
            5:       r_opc = 6'b001001;
            6:       r_opc = 6'b001010;
            default: r_opc = 6'($urandom);
         endcase
         r_fn  = 3'($urandom);
         r_aop = ($urandom_range(0, 7) != 0);
         if (r_rst) q.delete();
         else if (r_st && !cur.stall) expand(r_opc, r_fn, r_aop);
         reset = r_rst; Start = r_st; Opcode = r_opc; Func = r_fn; ALUOp = r_aop;
         @(posedge clk);
         @(negedge clk);
         cur = (q.size() == 0) ? out_t'('0) : q.pop_front();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
